// File: rtl/rbm_sched_pkg.sv
// Shared FSM type, CSR word addresses and status bit positions for the RBM read scheduler.
package rbm_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StGo,
    StWaitDone
  } sched_state_e;

  localparam logic [2:0] CsrStatus = 3'd0;
  localparam logic [2:0] CsrBase   = 3'd1;
  localparam logic [2:0] CsrLength = 3'd2;
  localparam logic [2:0] CsrCtrl   = 3'd3;
  localparam logic [2:0] CsrJobCnt = 3'd4;
  localparam logic [2:0] CsrIrq    = 3'd5;

  localparam int unsigned StatusBusy     = 0;
  localparam int unsigned StatusOverflow = 1;
  localparam int unsigned StatusEmpty    = 2;
  localparam int unsigned StatusFull     = 3;
  localparam int unsigned StatusCountLsb = 4;

endpackage

// File: rtl/rbm_desc_fifo.sv
// Show-ahead descriptor FIFO: rdata always presents the head entry while not empty.
module rbm_desc_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PtrW:0]    count
);

  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rbm_read_scheduler.sv
// Queues host-written read descriptors and issues them one at a time to the RBM memory reader.
// Define RBM_SCHED_IRQ_EN to add the ins_irq output and the interrupt CSR at address 5.
module rbm_read_scheduler
  import rbm_sched_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               avs_s0_address,
  input  logic                     avs_s0_read,
  input  logic                     avs_s0_write,
  input  logic [ADDRESS_WIDTH-1:0] avs_s0_writedata,
  output logic [ADDRESS_WIDTH-1:0] avs_s0_readdata,
  output logic                     avs_s0_readdatavalid,
  output logic                     coe_control_fixed_location,
  output logic [ADDRESS_WIDTH-1:0] coe_control_read_base,
  output logic [ADDRESS_WIDTH-1:0] coe_control_read_length,
  output logic                     coe_control_go,
  input  logic                     coe_control_done,
`ifdef RBM_SCHED_IRQ_EN
  input  logic                     coe_control_early_done,
  output logic                     ins_irq
`else
  input  logic                     coe_control_early_done
`endif
);

  localparam int unsigned AW     = ADDRESS_WIDTH;
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e         state_q;
  logic [AW-1:0]        staged_base_q, base_q, len_q, readdata_q, rd_mux, status;
  logic                 enable_q, overflow_q, go_q, rdv_q;
  logic [CNT_WIDTH-1:0] job_cnt_q;
  logic [2*AW-1:0]      fifo_wdata, fifo_rdata;
  logic [AW-1:0]        head_base, head_len;
  logic [CountW-1:0]    fifo_count;
  logic                 fifo_full, fifo_empty, fifo_pop, commit, job_done;
  logic                 unused_early_done;

  assign unused_early_done = coe_control_early_done;

  assign commit     = avs_s0_write && (avs_s0_address == CsrLength);
  assign fifo_wdata = {staged_base_q, avs_s0_writedata};
  assign fifo_pop   = (state_q == StLoad);
  assign head_base  = fifo_rdata[2*AW-1:AW];
  assign head_len   = fifo_rdata[AW-1:0];

  rbm_desc_fifo #(
    .Width(2 * AW),
    .Depth(FIFO_DEPTH)
  ) u_desc_fifo (
    .clk  (clk),
    .reset(reset),
    .push (commit),
    .pop  (fifo_pop),
    .wdata(fifo_wdata),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Zero-length descriptors retire in LOAD without ever reaching the reader.
  assign job_done = ((state_q == StLoad) && (head_len == '0)) ||
                    ((state_q == StWaitDone) && coe_control_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staged_base_q <= '0;
      enable_q      <= 1'b1;
      overflow_q    <= 1'b0;
    end else begin
      if (avs_s0_write && (avs_s0_address == CsrBase)) staged_base_q <= avs_s0_writedata;
      if (avs_s0_write && (avs_s0_address == CsrCtrl)) enable_q <= avs_s0_writedata[0];
      if (commit && fifo_full) begin
        overflow_q <= 1'b1;
      end else if (avs_s0_write && (avs_s0_address == CsrStatus) &&
                   avs_s0_writedata[StatusOverflow]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      go_q      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      job_cnt_q <= '0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        StIdle: if (!fifo_empty && enable_q) state_q <= StLoad;
        StLoad: begin
          base_q <= head_base;
          len_q  <= head_len;
          if (head_len == '0) begin
            state_q <= StIdle;
          end else begin
            go_q    <= 1'b1;
            state_q <= StGo;
          end
        end
        StGo:       state_q <= StWaitDone;
        StWaitDone: if (coe_control_done) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
      if (job_done) job_cnt_q <= job_cnt_q + CNT_WIDTH'(1);
    end
  end

`ifdef RBM_SCHED_IRQ_EN
  logic irq_en_q, pending_q, ins_irq_q, drained, wr_irq;

  assign wr_irq  = avs_s0_write && (avs_s0_address == CsrIrq);
  // Queue counts as drained when nothing remains after this cycle's pop and no new commit lands.
  assign drained = !commit && (fifo_empty || (fifo_pop && (fifo_count == CountW'(1))));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      ins_irq_q <= 1'b0;
    end else begin
      if (wr_irq) irq_en_q <= avs_s0_writedata[0];
      if (job_done && drained) begin
        pending_q <= 1'b1;
      end else if (wr_irq && avs_s0_writedata[1]) begin
        pending_q <= 1'b0;
      end
      ins_irq_q <= pending_q & irq_en_q;
    end
  end

  assign ins_irq = ins_irq_q;
`endif

  always_comb begin
    status                              = '0;
    status[StatusBusy]                  = (state_q != StIdle);
    status[StatusOverflow]              = overflow_q;
    status[StatusEmpty]                 = fifo_empty;
    status[StatusFull]                  = fifo_full;
    status[StatusCountLsb +: CountW]    = fifo_count;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_s0_address)
      CsrStatus: rd_mux = status;
      CsrBase:   rd_mux = staged_base_q;
      CsrCtrl:   rd_mux[0] = enable_q;
      CsrJobCnt: rd_mux[CNT_WIDTH-1:0] = job_cnt_q;
`ifdef RBM_SCHED_IRQ_EN
      CsrIrq:    rd_mux[1:0] = {pending_q, irq_en_q};
`endif
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      readdata_q <= avs_s0_read ? rd_mux : '0;
      rdv_q      <= avs_s0_read;
    end
  end

  assign avs_s0_readdata            = readdata_q;
  assign avs_s0_readdatavalid       = rdv_q;
  assign coe_control_fixed_location = 1'b0;
  assign coe_control_read_base      = base_q;
  assign coe_control_read_length    = len_q;
  assign coe_control_go             = go_q;

endmodule

// File: tb/tb_rbm_read_scheduler.sv
// Scoreboard bench for rbm_read_scheduler: queued go/CSR expectations checked by a monitor.
module tb_rbm_read_scheduler;

  localparam int unsigned AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [2:0]  A_STATUS = 3'd0, A_BASE = 3'd1, A_LEN = 3'd2, A_CTRL = 3'd3;
  localparam logic [2:0]  A_JOBCNT = 3'd4, A_IRQ = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    avs_s0_address;
  logic          avs_s0_read, avs_s0_write, avs_s0_readdatavalid;
  logic [AW-1:0] avs_s0_writedata, avs_s0_readdata;
  logic          coe_control_fixed_location, coe_control_go;
  logic          coe_control_done, coe_control_early_done;
  logic [AW-1:0] coe_control_read_base, coe_control_read_length;
`ifdef RBM_SCHED_IRQ_EN
  logic          ins_irq;
`endif

  always #5 clk = ~clk;

  rbm_read_scheduler dut (
    .clk                       (clk),
    .reset                     (reset),
    .avs_s0_address            (avs_s0_address),
    .avs_s0_read               (avs_s0_read),
    .avs_s0_write              (avs_s0_write),
    .avs_s0_writedata          (avs_s0_writedata),
    .avs_s0_readdata           (avs_s0_readdata),
    .avs_s0_readdatavalid      (avs_s0_readdatavalid),
    .coe_control_fixed_location(coe_control_fixed_location),
    .coe_control_read_base     (coe_control_read_base),
    .coe_control_read_length   (coe_control_read_length),
    .coe_control_go            (coe_control_go),
    .coe_control_done          (coe_control_done),
`ifdef RBM_SCHED_IRQ_EN
    .coe_control_early_done    (coe_control_early_done),
    .ins_irq                   (ins_irq)
`else
    .coe_control_early_done    (coe_control_early_done)
`endif
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            cyc;   // expected go sample index, -1 when not timed
  } desc_t;

  desc_t         exp_go[$];
  desc_t         m_q[$];
  logic [AW-1:0] exp_rd[$];

  int n_checks = 0, n_fail = 0, ncyc = 0;
  int m_jobcnt = 0;
  bit m_overflow = 1'b0, m_enable = 1'b1;
  bit job_open = 1'b0, reader_auto = 1'b1, spur_en = 1'b0, spur_req = 1'b0;
  int rd_fixed = 5, cd = 0, done_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: jobs run in commit order; while disabled the queue holds DEPTH entries.
  function automatic void launch(input desc_t d);
    m_jobcnt++;
    if (d.len != '0) exp_go.push_back(d);
  endfunction

  function automatic void model_commit(input logic [AW-1:0] b, input logic [AW-1:0] l,
                                       input int cyc);
    desc_t d;
    d.base = b;
    d.len  = l;
    d.cyc  = cyc;
    if (m_enable) launch(d);
    else if (m_q.size() < DEPTH) m_q.push_back(d);
    else m_overflow = 1'b1;
  endfunction

  function automatic void model_enable();
    m_enable = 1'b1;
    while (m_q.size() > 0) launch(m_q.pop_front());
  endfunction

  function automatic logic [AW-1:0] exp_status(input int cnt, input bit busy);
    logic [AW-1:0] s;
    s = AW'(cnt) << 4;
    if (cnt == DEPTH) s = s | 32'h8;
    if (cnt == 0)     s = s | 32'h4;
    if (m_overflow)   s = s | 32'h2;
    if (busy)         s = s | 32'h1;
    return s;
  endfunction

  // Driver tasks start and end 1 time unit after a falling edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [AW-1:0] d);
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    #1;
    avs_s0_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, input logic [AW-1:0] exp);
    exp_rd.push_back(exp);
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    @(negedge clk);
    #1;
    avs_s0_read = 1'b0;
  endtask

  task automatic commit_desc(input logic [AW-1:0] b, input logic [AW-1:0] l, input int cyc);
    model_commit(b, l, cyc);
    csr_write(A_BASE, b);
    csr_write(A_LEN, l);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a read response or a go pulse.
  initial begin
    desc_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (avs_s0_readdatavalid) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected readdatavalid: data 0x%0h, no read outstanding",
                   avs_s0_readdata);
        end else begin
          check("csr readdata", avs_s0_readdata, exp_rd.pop_front());
        end
      end
      if (coe_control_go) begin
        check("go while job open", job_open, 0);
        job_open = 1'b1;
        if (exp_go.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected go: base 0x%0h length 0x%0h, none expected",
                   coe_control_read_base, coe_control_read_length);
        end else begin
          e = exp_go.pop_front();
          check("go base", coe_control_read_base, e.base);
          check("go length", coe_control_read_length, e.len);
          if (e.cyc >= 0) check("go cycle", ncyc, e.cyc);
        end
      end
    end
  end

  // Reader model: answers each go with done after a delay; may pulse done early in the GO cycle.
  initial begin
    coe_control_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      coe_control_done = 1'b0;
      if (spur_req) begin
        coe_control_done = 1'b1;
        spur_req = 1'b0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          coe_control_done = 1'b1;
          job_open = 1'b0;
          done_count++;
        end
      end else if (reader_auto && coe_control_go) begin
        cd = (rd_fixed > 0) ? rd_fixed : int'($urandom_range(1, 6));
        if (spur_en && ($urandom_range(0, 2) == 0)) coe_control_done = 1'b1;
      end
    end
  end

  initial begin
    logic [AW-1:0] b, l;
    int            n, irq_seen, base_done;

    reset                  = 1'b1;
    avs_s0_address         = '0;
    avs_s0_read            = 1'b0;
    avs_s0_write           = 1'b0;
    avs_s0_writedata       = '0;
    coe_control_early_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {avs_s0_readdata, avs_s0_readdatavalid, coe_control_fixed_location,
                            coe_control_read_base, coe_control_read_length, coe_control_go}, 0);
    #1;
    reset = 1'b0;

    csr_read(A_STATUS, exp_status(0, 1'b0));
    csr_read(A_CTRL, 32'h1);
    csr_read(A_JOBCNT, 32'h0);
    csr_read(A_IRQ, 32'h0);
    csr_read(3'd6, 32'h0);
    csr_read(3'd7, 32'h0);

    // Single job: go exactly 2 edges after the committing write, busy while active.
    rd_fixed = 5;
    csr_write(A_BASE, 32'h1000);
    model_commit(32'h1000, 32'h40, ncyc + 3);
    csr_write(A_LEN, 32'h40);
    wait_cycles(2);
    csr_read(A_STATUS, exp_status(0, 1'b1));
    wait_cycles(12);
    csr_read(A_JOBCNT, AW'(m_jobcnt));
    csr_read(A_STATUS, exp_status(0, 1'b0));
    csr_read(A_BASE, 32'h1000);

    // Three back-to-back descriptors, done 5 cycles after each go.
    commit_desc(32'h2000, 32'h10, -1);
    commit_desc(32'h3000, 32'h20, -1);
    commit_desc(32'h4000, 32'h30, -1);
    wait_cycles(40);
    csr_read(A_JOBCNT, AW'(m_jobcnt));

    // Overflow: six commits while disabled, clear overflow, then enable.
    csr_write(A_CTRL, 32'h0);
    m_enable = 1'b0;
    for (int i = 0; i < 6; i++) commit_desc(32'h5000 + 32'(i) * 32'h100, 32'h8 + 32'(i), -1);
    csr_read(A_STATUS, exp_status(m_q.size(), 1'b0));
    csr_read(A_CTRL, 32'h0);
    csr_write(A_STATUS, 32'h2);
    m_overflow = 1'b0;
    csr_read(A_STATUS, exp_status(m_q.size(), 1'b0));
    csr_write(A_CTRL, 32'h1);
    model_enable();
    wait_cycles(60);
    csr_read(A_JOBCNT, AW'(m_jobcnt));
    csr_read(A_STATUS, exp_status(0, 1'b0));

    // Zero-length descriptor between two normal jobs.
    commit_desc(32'h6000, 32'h44, -1);
    commit_desc(32'h6100, 32'h0, -1);
    commit_desc(32'h6200, 32'h88, -1);
    wait_cycles(40);
    csr_read(A_JOBCNT, AW'(m_jobcnt));

    // Randomized batches with random reader latency and spurious done pulses.
    rd_fixed = 0;
    spur_en  = 1'b1;
    for (int it = 0; it < 20; it++) begin
      csr_write(A_CTRL, 32'h0);
      m_enable = 1'b0;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = $urandom;
        l = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        commit_desc(b, l, -1);
      end
      csr_read(A_STATUS, exp_status(m_q.size(), 1'b0));
      if ($urandom_range(0, 1) == 1) begin
        csr_write(A_STATUS, 32'h2);
        m_overflow = 1'b0;
      end
      csr_write(A_CTRL, 32'h1);
      model_enable();
      wait_cycles(70);
      spur_req = 1'b1;
      wait_cycles(3);
      csr_read(A_JOBCNT, AW'(m_jobcnt % 65536));
      csr_read(A_STATUS, exp_status(0, 1'b0));
    end
    spur_en = 1'b0;

    // Reset during WAIT_DONE with two jobs still queued.
    reader_auto = 1'b0;
    model_commit(32'h7000, 32'h70, -1);
    csr_write(A_BASE, 32'h7000);
    csr_write(A_LEN, 32'h70);
    csr_write(A_BASE, 32'h7100);
    csr_write(A_LEN, 32'h71);
    csr_write(A_BASE, 32'h7200);
    csr_write(A_LEN, 32'h72);
    wait_cycles(6);
    reset = 1'b1;
    #1;
`ifdef RBM_SCHED_IRQ_EN
    check("irq under reset", ins_irq, 0);
`endif
    check("outputs under reset", {avs_s0_readdata, avs_s0_readdatavalid,
                                  coe_control_fixed_location, coe_control_read_base,
                                  coe_control_read_length, coe_control_go}, 0);
    wait_cycles(2);
    reset       = 1'b0;
    job_open    = 1'b0;
    m_jobcnt    = 0;
    m_overflow  = 1'b0;
    m_enable    = 1'b1;
    reader_auto = 1'b1;
    rd_fixed    = 3;
    csr_read(A_STATUS, exp_status(0, 1'b0));
    csr_read(A_CTRL, 32'h1);
    csr_read(A_BASE, 32'h0);
    spur_req = 1'b1;
    wait_cycles(4);
    csr_read(A_JOBCNT, 32'h0);
    wait_cycles(10);

`ifdef RBM_SCHED_IRQ_EN
    // Interrupt fires only once the queue has drained.
    csr_write(A_IRQ, 32'h3);
    csr_write(A_CTRL, 32'h0);
    m_enable = 1'b0;
    commit_desc(32'h8000, 32'h18, -1);
    commit_desc(32'h8100, 32'h28, -1);
    base_done = done_count;
    csr_write(A_CTRL, 32'h1);
    model_enable();
    irq_seen = 0;
    for (int i = 0; i < 60; i++) begin
      wait_cycles(1);
      if (ins_irq && (irq_seen == 0)) begin
        irq_seen = 1;
        check("dones before irq", done_count - base_done, 2);
      end
    end
    check("irq raised", irq_seen, 1);
    csr_read(A_IRQ, 32'h3);
    csr_write(A_IRQ, 32'h2);
    wait_cycles(2);
    check("irq cleared", ins_irq, 0);
    csr_read(A_IRQ, 32'h0);
    csr_read(A_JOBCNT, AW'(m_jobcnt));
`endif

    wait_cycles(5);
    check("pending go expectations", exp_go.size(), 0);
    check("pending read expectations", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
